cnn_layer_accel_weight_seq_ctrl: RTL and testbench
==================================================

CNN_LAYER_ACCEL_WEIGHT_SEQ_CTRL -- requirements
Module: cnn_layer_accel_weight_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_WHT_SEQ_VALUES, default 5: entries per kernel in the weight-sequence table.
REQ-002 SHALL have parameter WHT_SEQ_WIDTH, default 4: width of each table entry.
REQ-003 SHALL have parameter WHT_ADDR_WIDTH, default 12: weight-RAM address width.
REQ-004 SHALL have parameter KRNL_CNT_WIDTH, default 8: kernel-count width.
REQ-005 SHALL have parameter KRNL_STRIDE, default 10: weight-RAM words per kernel.
REQ-006 SHALL have port clk  in  1: the only clock.
REQ-007 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-008 SHALL have port start  in  1: one-cycle run request.
REQ-009 SHALL have port num_kernels  in  KRNL_CNT_WIDTH: kernel count, sampled with start.
REQ-010 SHALL have port busy  out  1: run in progress.
REQ-011 SHALL have port done  out  1: one-cycle end-of-run pulse.
REQ-012 SHALL have port seq_rdAddr  out  clog2(NUM_WHT_SEQ_VALUES): table read address.
REQ-013 SHALL have port seq_rden  out  1: table sequential-step flag.
REQ-014 SHALL have ports seq_dout0 and seq_dout1  in  WHT_SEQ_WIDTH each: registered table data.
REQ-015 SHALL have ports wht_addr0 and wht_addr1  out  WHT_ADDR_WIDTH each: weight-RAM address pair.
REQ-016 SHALL have port wht_valid  out  1: address pair valid.
REQ-017 SHALL have port wht_ready  in  1: downstream accepts the pair.
REQ-018 SHALL have port wht_last  out  1: final pair of the run.

Function
REQ-019 Table protocol: 1-cycle read latency; seq_dout0/1 in cycle t+1 = entry at the index issued in cycle t. seq_rden=1 only when the issued index = previous issued index + 1; otherwise seq_rden=0. seq_rdAddr always carries the issued index.
REQ-020 FSM states: IDLE, RUN, DRAIN.
REQ-021 IDLE->RUN on start with num_kernels != 0: latch num_kernels, clear kernel_idx, clear base; busy=1 from the next cycle.
REQ-022 start with num_kernels=0 SHALL produce a done pulse in the next cycle, issue no pairs, and stay in IDLE.
REQ-023 start while busy SHALL be ignored.
REQ-024 In RUN, issue index 0 in the first cycle. Each following cycle:
- if the previous cycle's issue is captured, issue the next index;
- otherwise reissue the same index with seq_rden=0.
REQ-025 Capture: the output register loads when an issue is outstanding and (!wht_valid || wht_ready), giving wht_addr0 = base + seq_dout0 and wht_addr1 = base + seq_dout1. Additions are modulo 2^WHT_ADDR_WIDTH, with the table data zero-extended.
REQ-026 Wrap-around: after index NUM_WHT_SEQ_VALUES-1 is captured, the next issue is index 0 with seq_rden=0, base += KRNL_STRIDE, and kernel_idx++.
REQ-027 The capture of the last index of kernel num_kernels-1 SHALL set wht_last with that pair, stop issuing, and move the FSM to DRAIN.
REQ-028 DRAIN->IDLE when the last pair handshakes (wht_valid && wht_ready); done=1 in the following cycle, and busy=0 in that same cycle.
REQ-029 wht_valid SHALL remain set and wht_addr0/1 and wht_last SHALL hold while wht_ready=0.
REQ-030 Throughput SHALL be one pair per cycle with wht_ready held high, including across kernel wrap.
REQ-031 Latency: start accepted in cycle t -> first wht_valid in cycle t+3.

Reset
REQ-032 rst SHALL force: IDLE; busy=0, done=0, wht_valid=0, wht_last=0, seq_rden=0, seq_rdAddr=0, wht_addr0=0, wht_addr1=0; counters and base cleared.
REQ-033 rst asserted mid-run SHALL abort the run with no done pulse; a start in the first cycle after rst is deasserted SHALL be accepted.

Verification
Bench table model: seq0 = {0,1,4,5,6} and seq1 = {2,3,7,8,9} at indices 0..4, with 1-cycle registered latency.
REQ-034 start, num_kernels=1, wht_ready=1 -> pairs (0,2),(1,3),(4,7),(5,8),(6,9) in cycles t+3..t+7; wht_last on (6,9); done at t+8.
REQ-035 num_kernels=2, wht_ready=1 -> 10 consecutive pairs, the second kernel offset by 10 ((10,12)..(16,19)); seq_rden=0 at the wrap issue.
REQ-036 wht_ready=0 for 3 cycles while (4,7) is valid -> (4,7) held; seq_rdAddr reissued with seq_rden=0; no pair lost or duplicated.
REQ-037 start with num_kernels=0 -> done one cycle later, wht_valid never set; start during busy -> ignored, pair count unchanged.
REQ-038 rst during the third pair -> all outputs at reset values the next cycle; a new start with num_kernels=1 reproduces the REQ-034 sequence.
REQ-039 WHT_ADDR_WIDTH=4, num_kernels=2 -> second-kernel addresses wrap modulo 16 ((10,12),(11,13),(14,1),(15,2),(0,3)).

Source files
------------

// File: rtl/cnn_layer_accel_weight_seq_ctrl.sv
// rtl/cnn_layer_accel_weight_seq_ctrl.sv - weight-sequence table walker producing weight-RAM address pairs
module cnn_layer_accel_weight_seq_ctrl #(
    parameter int NUM_WHT_SEQ_VALUES = 5,
    parameter int WHT_SEQ_WIDTH      = 4,
    parameter int WHT_ADDR_WIDTH     = 12,
    parameter int KRNL_CNT_WIDTH     = 8,
    parameter int KRNL_STRIDE        = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [KRNL_CNT_WIDTH-1:0]             num_kernels,
    output logic                                  busy,
    output logic                                  done,
    output logic [$clog2(NUM_WHT_SEQ_VALUES)-1:0] seq_rdAddr,
    output logic                                  seq_rden,
    input  logic [WHT_SEQ_WIDTH-1:0]              seq_dout0,
    input  logic [WHT_SEQ_WIDTH-1:0]              seq_dout1,
    output logic [WHT_ADDR_WIDTH-1:0]             wht_addr0,
    output logic [WHT_ADDR_WIDTH-1:0]             wht_addr1,
    output logic                                  wht_valid,
    input  logic                                  wht_ready,
    output logic                                  wht_last
);

    localparam int IDX_W = $clog2(NUM_WHT_SEQ_VALUES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]                state;
    logic [KRNL_CNT_WIDTH-1:0] krnl_cnt;
    logic [KRNL_CNT_WIDTH-1:0] kernel_idx;   // kernel of the outstanding issue
    logic [WHT_ADDR_WIDTH-1:0] base;         // base address of the outstanding issue
    logic                      prev_vld;     // an index was issued last cycle
    logic [IDX_W-1:0]          prev_idx;     // index issued last cycle

    logic             capture;
    logic             at_end;
    logic             last_kernel;
    logic             last_cap;
    logic             wrap;
    logic             issue;
    logic [IDX_W-1:0] issue_idx;
    logic             accept;

    assign busy   = (state != ST_IDLE);
    assign accept = (state == ST_IDLE) && start && (num_kernels != '0);

    // Decide this cycle's capture of table data and the index to issue next
    always_comb begin
        capture     = prev_vld && (!wht_valid || wht_ready);
        at_end      = (prev_idx == IDX_W'(NUM_WHT_SEQ_VALUES - 1));
        last_kernel = (kernel_idx == krnl_cnt - KRNL_CNT_WIDTH'(1));
        last_cap    = capture && at_end && last_kernel;
        wrap        = capture && at_end && !last_kernel;
        issue       = (state == ST_RUN) && !last_cap;
        issue_idx   = '0;
        if (prev_vld) begin
            if (capture) begin
                issue_idx = at_end ? '0 : prev_idx + IDX_W'(1);
            end else begin
                issue_idx = prev_idx;
            end
        end
        seq_rdAddr = issue ? issue_idx : '0;
        seq_rden   = issue && capture && !at_end;
    end

    // Run-level FSM, kernel/base tracking and issue history
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            done       <= 1'b0;
            krnl_cnt   <= '0;
            kernel_idx <= '0;
            base       <= '0;
            prev_vld   <= 1'b0;
            prev_idx   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_kernels == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= ST_RUN;
                            krnl_cnt <= num_kernels;
                        end
                    end
                end
                ST_RUN: begin
                    if (last_cap) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (wht_valid && wht_ready && wht_last) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (accept) begin
                kernel_idx <= '0;
                base       <= '0;
            end else if (wrap) begin
                kernel_idx <= kernel_idx + KRNL_CNT_WIDTH'(1);
                base       <= base + WHT_ADDR_WIDTH'(KRNL_STRIDE);
            end

            prev_vld <= issue;
            prev_idx <= issue ? issue_idx : '0;
        end
    end

    // Output pair register: load on capture, hold while stalled, empty on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            wht_valid <= 1'b0;
            wht_last  <= 1'b0;
            wht_addr0 <= '0;
            wht_addr1 <= '0;
        end else if (capture) begin
            wht_valid <= 1'b1;
            wht_last  <= last_cap;
            wht_addr0 <= base + WHT_ADDR_WIDTH'(seq_dout0);
            wht_addr1 <= base + WHT_ADDR_WIDTH'(seq_dout1);
        end else if (wht_ready) begin
            wht_valid <= 1'b0;
            wht_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_weight_seq_ctrl.sv
// tb/tb_cnn_layer_accel_weight_seq_ctrl.sv - scoreboard bench for the weight-sequence controller
module tb_cnn_layer_accel_weight_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] num_kernels;
    logic       wht_ready;

    logic        busy_a, done_a, rden_a, valid_a, last_a;
    logic [2:0]  rd_a;
    logic [3:0]  d0_a, d1_a;
    logic [11:0] a0_a, a1_a;

    logic        busy_b, done_b, rden_b, valid_b, last_b;
    logic [2:0]  rd_b;
    logic [3:0]  d0_b, d1_b;
    logic [3:0]  a0_b, a1_b;

    logic [3:0] seq0 [0:4] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6};
    logic [3:0] seq1 [0:4] = '{4'd2, 4'd3, 4'd7, 4'd8, 4'd9};

    logic [31:0] qa [$];
    logic [31:0] qb [$];

    int checks = 0;
    int errors = 0;
    int pairs_a = 0;
    int n;
    int p0;

    cnn_layer_accel_weight_seq_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start), .num_kernels(num_kernels),
        .busy(busy_a), .done(done_a), .seq_rdAddr(rd_a), .seq_rden(rden_a),
        .seq_dout0(d0_a), .seq_dout1(d1_a), .wht_addr0(a0_a), .wht_addr1(a1_a),
        .wht_valid(valid_a), .wht_ready(wht_ready), .wht_last(last_a)
    );

    cnn_layer_accel_weight_seq_ctrl #(.WHT_ADDR_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .num_kernels(num_kernels),
        .busy(busy_b), .done(done_b), .seq_rdAddr(rd_b), .seq_rden(rden_b),
        .seq_dout0(d0_b), .seq_dout1(d1_b), .wht_addr0(a0_b), .wht_addr1(a1_b),
        .wht_valid(valid_b), .wht_ready(wht_ready), .wht_last(last_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered weight-sequence tables, one per DUT
    always @(posedge clk) begin
        d0_a <= (rd_a < 3'd5) ? seq0[rd_a] : 4'd0;
        d1_a <= (rd_a < 3'd5) ? seq1[rd_a] : 4'd0;
        d0_b <= (rd_b < 3'd5) ? seq0[rd_b] : 4'd0;
        d1_b <= (rd_b < 3'd5) ? seq1[rd_b] : 4'd0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int nk);
        for (int k = 0; k < nk; k++) begin
            for (int i = 0; i < 5; i++) begin
                logic [31:0] ea;
                logic [31:0] eb;
                logic [11:0] x0;
                logic [11:0] x1;
                logic        l;
                x0 = 12'(k * 10 + int'(seq0[i]));
                x1 = 12'(k * 10 + int'(seq1[i]));
                l  = (k == nk - 1) && (i == 4);
                ea = {7'd0, x0, x1, l};
                eb = {23'd0, x0[3:0], x1[3:0], l};
                qa.push_back(ea);
                qb.push_back(eb);
            end
        end
    endtask

    task automatic wait_done(input int limit, output int waited);
        waited = 0;
        while (waited < limit) begin
            cyc();
            @(negedge clk);
            waited++;
            if (done_a) break;
        end
        check("done_within_limit", {31'd0, done_a}, 32'd1);
    endtask

    // Scoreboard: every handshaked pair is popped and compared
    always @(negedge clk) begin
        if (!rst && valid_a && wht_ready) begin
            pairs_a++;
            check("pair_a", {7'd0, a0_a, a1_a, last_a}, (qa.size() != 0) ? qa.pop_front() : 32'hDEAD_BEEF);
        end
        if (!rst && valid_b && wht_ready) begin
            check("pair_b", {23'd0, a0_b, a1_b, last_b}, (qb.size() != 0) ? qb.pop_front() : 32'hDEAD_BEEF);
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; num_kernels = 8'd0; wht_ready = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_valid_last", {30'd0, valid_a, last_a}, 32'd0);
        check("rst_rd", {28'd0, rden_a, rd_a}, 32'd0);
        check("rst_addr", {8'd0, a0_a, a1_a}, 32'd0);
        cyc(); rst = 1'b0;

        // single kernel, ready held high
        cyc(); start = 1'b1; num_kernels = 8'd1; push_run(1);
        @(negedge clk);
        check("t0_busy", {31'd0, busy_a}, 32'd0);
        cyc(); start = 1'b0;
        @(negedge clk);
        check("t1_busy", {31'd0, busy_a}, 32'd1);
        check("t1_issue", {28'd0, rden_a, rd_a}, 32'd0);
        check("t1_valid", {31'd0, valid_a}, 32'd0);
        cyc(); @(negedge clk);
        check("t2_issue", {28'd0, rden_a, rd_a}, {28'd0, 1'b1, 3'd1});
        check("t2_valid", {31'd0, valid_a}, 32'd0);
        cyc(); @(negedge clk);
        check("t3_valid", {31'd0, valid_a}, 32'd1);
        repeat (4) cyc();
        @(negedge clk);
        check("t7_last", {30'd0, valid_a, last_a}, 32'd3);
        cyc(); @(negedge clk);
        check("t8_done_busy_valid", {29'd0, done_a, busy_a, valid_a}, 32'd4);
        cyc(); @(negedge clk);
        check("t9_done", {31'd0, done_a}, 32'd0);
        check("run1_queue_empty", qa.size(), 32'd0);

        // two kernels, wrap and throughput
        p0 = pairs_a;
        cyc(); start = 1'b1; num_kernels = 8'd2; push_run(2);
        cyc(); start = 1'b0;
        repeat (5) cyc();
        @(negedge clk);
        check("wrap_issue", {27'd0, busy_a, rden_a, rd_a}, {27'd0, 1'b1, 1'b0, 3'd0});
        wait_done(30, n);
        check("run2_done_cycle", n, 32'd7);
        check("run2_pairs", pairs_a - p0, 32'd10);
        check("run2_queue_a", qa.size(), 32'd0);
        check("run2_queue_b", qb.size(), 32'd0);

        // backpressure on the third pair
        p0 = pairs_a;
        cyc(); start = 1'b1; num_kernels = 8'd1; push_run(1);
        cyc(); start = 1'b0;
        repeat (4) cyc();
        wht_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_pair", {7'd0, a0_a, a1_a, valid_a}, {7'd0, 12'd4, 12'd7, 1'b1});
            check("stall_issue", {28'd0, rden_a, rd_a}, {28'd0, 1'b0, 3'd3});
            if (s < 2) cyc();
        end
        cyc(); wht_ready = 1'b1;
        wait_done(20, n);
        check("stall_done_cycle", n, 32'd3);
        check("stall_pairs", pairs_a - p0, 32'd5);
        check("stall_queue", qa.size(), 32'd0);

        // zero kernels
        cyc(); start = 1'b1; num_kernels = 8'd0;
        cyc(); start = 1'b0;
        @(negedge clk);
        check("zero_done", {29'd0, done_a, busy_a, valid_a}, 32'd4);
        cyc(); @(negedge clk);
        check("zero_after", {29'd0, done_a, busy_a, valid_a}, 32'd0);

        // start while busy is ignored
        p0 = pairs_a;
        cyc(); start = 1'b1; num_kernels = 8'd1; push_run(1);
        cyc(); start = 1'b0;
        cyc(); start = 1'b1; num_kernels = 8'd2;
        cyc(); start = 1'b0;
        wait_done(20, n);
        check("busy_start_pairs", pairs_a - p0, 32'd5);
        cyc(); @(negedge clk);
        check("busy_start_idle", {30'd0, busy_a, valid_a}, 32'd0);
        check("busy_start_queue", qa.size(), 32'd0);

        // reset during third pair, then immediate restart
        cyc(); start = 1'b1; num_kernels = 8'd1; push_run(1);
        cyc(); start = 1'b0;
        repeat (4) cyc();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_third", {19'd0, a0_a, valid_a}, {19'd0, 12'd4, 1'b1});
        cyc(); @(negedge clk);
        check("rst_mid_ctrl", {27'd0, busy_a, done_a, valid_a, last_a, rden_a}, 32'd0);
        check("rst_mid_addr", {5'd0, rd_a, a0_a, a1_a}, 32'd0);
        qa.delete(); qb.delete();
        p0 = pairs_a;
        cyc(); rst = 1'b0; start = 1'b1; num_kernels = 8'd1; push_run(1);
        cyc(); start = 1'b0;
        @(negedge clk);
        check("restart_busy", {31'd0, busy_a}, 32'd1);
        wait_done(20, n);
        check("restart_pairs", pairs_a - p0, 32'd5);
        check("restart_queue", qa.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
